// File: rtl/draw_scoreboard.sv
// draw_scoreboard: overlays NUM_PLAYERS decimal score fields on the VGA pixel stream.
// Scores are snapshotted once per frame and turned into BCD by a serial double-dabble FSM.
module draw_scoreboard #(
  parameter int          NUM_PLAYERS = 2,
  parameter int          SCORE_W     = 7,
  parameter int          DIGITS      = 2,
  parameter int          X_START     = 448,
  parameter int          X_PITCH     = 96,
  parameter int          Y_START     = 32,
  parameter int          SCALE_LOG2  = 1,
  parameter logic [11:0] FG_COLOR    = 12'hFFF,
  parameter bit          LZ_BLANK    = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [10:0]                    hcount_in,
  input  logic [10:0]                    vcount_in,
  input  logic                           hsync_in,
  input  logic                           vsync_in,
  input  logic                           hblnk_in,
  input  logic                           vblnk_in,
  input  logic [11:0]                    rgb_in,
  input  logic [NUM_PLAYERS*SCORE_W-1:0] score_in,
  output logic [6:0]                     char_code,
  output logic [3:0]                     char_line,
  input  logic [7:0]                     char_pixel,
  output logic [10:0]                    hcount_out,
  output logic [10:0]                    vcount_out,
  output logic                           hsync_out,
  output logic                           vsync_out,
  output logic                           hblnk_out,
  output logic                           vblnk_out,
  output logic [11:0]                    rgb_out,
  output logic                           busy,
  output logic [NUM_PLAYERS-1:0]         overflow
);

  localparam int BCD_W   = 4 * DIGITS;
  localparam int TOT_W   = NUM_PLAYERS * BCD_W;
  localparam int PW      = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int CW      = $clog2(SCORE_W + 1);
  localparam int FIELD_W = DIGITS * 8 << SCALE_LOG2;
  localparam int FIELD_H = 16 << SCALE_LOG2;
  localparam logic [31:0] MAX_VAL = 32'(10 ** DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CONV, SAT, COMMIT} state_t;
  state_t state, state_nxt;

  logic                           vsync_prev;
  logic                           vsync_rise;
  logic [NUM_PLAYERS*SCORE_W-1:0] snap;
  logic [NUM_PLAYERS*SCORE_W-1:0] snap_shifted;
  logic [SCORE_W-1:0]             bin_sh;
  logic [BCD_W-1:0]               bcd_sh;
  logic [BCD_W-1:0]               bcd_adj;
  logic [BCD_W-1:0]               bcd_final;
  logic [CW-1:0]                  bit_cnt;
  logic [PW-1:0]                  player;
  logic [TOT_W-1:0]               work_bcd;
  logic [TOT_W-1:0]               disp_bcd;
  logic [NUM_PLAYERS-1:0]         work_ovf;
  logic                           sat_hit;
  logic                           last_bit;
  logic                           last_player;

  // The snapshot is consumed one player at a time from its low end.
  assign vsync_rise   = vsync_in & ~vsync_prev;
  assign snap_shifted = snap >> SCORE_W;
  assign sat_hit      = 32'(snap[SCORE_W-1:0]) > MAX_VAL;
  assign bcd_final    = sat_hit ? {DIGITS{4'd9}} : bcd_sh;
  assign last_bit     = (bit_cnt == CW'(SCORE_W - 1));
  assign last_player  = (player == PW'(NUM_PLAYERS - 1));

  always_comb begin
    bcd_adj = bcd_sh;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_sh[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_sh[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (vsync_rise) state_nxt = CONV;
      end
      CONV:    if (last_bit) state_nxt = SAT;
      SAT:     state_nxt = last_player ? COMMIT : CONV;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_prev <= 1'b0;
      snap       <= '0;
      bin_sh     <= '0;
      bcd_sh     <= '0;
      bit_cnt    <= '0;
      player     <= '0;
      work_bcd   <= '0;
      work_ovf   <= '0;
      disp_bcd   <= '0;
      overflow   <= '0;
    end else begin
      vsync_prev <= vsync_in;
      case (state)
        IDLE: begin
          if (vsync_rise) begin
            snap    <= score_in;
            bin_sh  <= score_in[SCORE_W-1:0];
            bcd_sh  <= '0;
            bit_cnt <= '0;
            player  <= '0;
          end
        end
        CONV: begin
          bcd_sh  <= {bcd_adj[BCD_W-2:0], bin_sh[SCORE_W-1]};
          bin_sh  <= bin_sh << 1;
          bit_cnt <= bit_cnt + CW'(1);
        end
        SAT: begin
          work_bcd[player*BCD_W +: BCD_W] <= bcd_final;
          work_ovf[player]                <= sat_hit;
          snap    <= snap_shifted;
          bin_sh  <= snap_shifted[SCORE_W-1:0];
          bcd_sh  <= '0;
          bit_cnt <= '0;
          player  <= player + PW'(1);
        end
        COMMIT: begin
          disp_bcd <= work_bcd;
          overflow <= work_ovf;
        end
        default: ;
      endcase
    end
  end

  logic [11:0] hc, vc, dx, dy, fx;
  logic        in_y, hit, lz;
  logic [2:0]  col_d;
  logic [3:0]  line_d;
  logic [6:0]  code_d;
  logic [8:0]  dig_idx;
  logic [3:0]  dig_val;

  // Unsigned offsets wrap to large values, so pixels left of or above a field miss it.
  always_comb begin
    hc      = {1'b0, hcount_in};
    vc      = {1'b0, vcount_in};
    dy      = vc - 12'(Y_START);
    in_y    = (vc >= 12'(Y_START)) && (dy < 12'(FIELD_H)) && !hblnk_in && !vblnk_in;
    hit     = 1'b0;
    code_d  = 7'h20;
    line_d  = 4'd0;
    col_d   = 3'd0;
    fx      = '0;
    dx      = '0;
    dig_idx = '0;
    dig_val = '0;
    lz      = 1'b0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      fx = 12'(X_START + p * X_PITCH);
      dx = hc - fx;
      if (in_y && (hc >= fx) && (dx < 12'(FIELD_W))) begin
        hit     = 1'b1;
        col_d   = 3'(dx >> SCALE_LOG2);
        line_d  = 4'(dy >> SCALE_LOG2);
        dig_idx = 9'(dx >> (SCALE_LOG2 + 3));
        lz      = LZ_BLANK && (dig_idx != 9'(DIGITS - 1));
        dig_val = '0;
        for (int k = 0; k < DIGITS; k++) begin
          if (9'(k) == dig_idx) dig_val = disp_bcd[p*BCD_W + (DIGITS-1-k)*4 +: 4];
          if ((9'(k) <= dig_idx) && (disp_bcd[p*BCD_W + (DIGITS-1-k)*4 +: 4] != 4'd0)) lz = 1'b0;
        end
        code_d = lz ? 7'h20 : {3'b011, dig_val};
      end
    end
  end

  logic [10:0] h1, v1;
  logic        hs1, vs1, hb1, vb1, in1, in2;
  logic [2:0]  col1, col2;
  logic [11:0] rgb1, rgb2;

  // Stage 1 addresses the font ROM; stage 2 lines up with its registered row data.
  always_ff @(posedge clk) begin
    if (rst) begin
      char_code  <= 7'h20;
      char_line  <= '0;
      col1       <= '0;
      in1        <= 1'b0;
      h1         <= '0;
      v1         <= '0;
      hs1        <= 1'b0;
      vs1        <= 1'b0;
      hb1        <= 1'b0;
      vb1        <= 1'b0;
      rgb1       <= '0;
      col2       <= '0;
      in2        <= 1'b0;
      rgb2       <= '0;
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
    end else begin
      char_code  <= code_d;
      char_line  <= line_d;
      col1       <= col_d;
      in1        <= hit;
      h1         <= hcount_in;
      v1         <= vcount_in;
      hs1        <= hsync_in;
      vs1        <= vsync_in;
      hb1        <= hblnk_in;
      vb1        <= vblnk_in;
      rgb1       <= rgb_in;
      col2       <= col1;
      in2        <= in1;
      rgb2       <= rgb1;
      hcount_out <= h1;
      vcount_out <= v1;
      hsync_out  <= hs1;
      vsync_out  <= vs1;
      hblnk_out  <= hb1;
      vblnk_out  <= vb1;
    end
  end

  assign rgb_out = (in2 && char_pixel[3'd7 - col2]) ? FG_COLOR : rgb2;

endmodule

// File: tb/tb_draw_scoreboard.sv
// tb_draw_scoreboard: randomized stimulus with a queue-based scoreboard against a
// behavioural model of the score overlay (decimal digits computed with / and %).
module tb_draw_scoreboard;

  localparam int NP = 2, SW = 7, DIG = 2, XS = 448, XP = 96, YS = 32, SL = 1;
  localparam int SC = 1 << SL;
  localparam int MAXV = 99;
  localparam int CONV_CYC = NP * (SW + 1) + 1;
  localparam logic [11:0] FG = 12'hFFF;

  logic clk = 1'b0, rst = 1'b1;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [NP*SW-1:0] score_in = '0;
  logic [6:0] char_code;
  logic [3:0] char_line;
  logic [7:0] char_pixel = '0;
  logic [10:0] hcount_out, vcount_out;
  logic hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic busy;
  logic [NP-1:0] overflow;

  draw_scoreboard #(
    .NUM_PLAYERS(NP), .SCORE_W(SW), .DIGITS(DIG), .X_START(XS), .X_PITCH(XP),
    .Y_START(YS), .SCALE_LOG2(SL), .FG_COLOR(FG), .LZ_BLANK(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .score_in(score_in),
    .char_code(char_code), .char_line(char_line), .char_pixel(char_pixel),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int font_mode = 1;

  function automatic logic [7:0] font_row(input logic [6:0] code, input logic [3:0] line);
    int v;
    if (font_mode == 0) return 8'h80;
    v = int'(code) * 37 + int'(line) * 11;
    return 8'(v) ^ 8'hA5;
  endfunction

  // Font ROM stand-in with one cycle of read latency.
  always @(posedge clk) char_pixel <= font_row(char_code, char_line);

  typedef struct packed {
    int          t;
    logic [6:0]  code;
    logic [3:0]  line;
    logic [11:0] rgb;
    logic [25:0] timing;
  } exp_t;
  exp_t exp_q[$];

  int  disp_score[NP];
  int  pend_score[NP];
  bit  conv_valid = 0, rst_pend = 0, prev_vs = 0, armed = 0;
  int  conv_start = 0, rst_at = 0;
  int  errors = 0, checks = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, want, cyc);
    end
  endtask

  function automatic bit model_busy(input int t);
    return conv_valid && (t >= conv_start) && (t < conv_start + CONV_CYC);
  endfunction

  function automatic int digit_of(input int score, input int k);
    int val = (score > MAXV) ? MAXV : score;
    return (val / (10 ** (DIG - 1 - k))) % 10;
  endfunction

  task automatic advance(input int t);
    if (rst_pend && t >= rst_at) begin
      rst_pend = 0;
      conv_valid = 0;
      foreach (disp_score[p]) disp_score[p] = 0;
    end
    if (conv_valid && t >= conv_start + CONV_CYC) begin
      conv_valid = 0;
      foreach (disp_score[p]) disp_score[p] = pend_score[p];
    end
  endtask

  task automatic applyStimulus(input int h, input int v, input bit hs, input bit vs,
                               input bit hb, input bit vb, input logic [11:0] rgb, input bit r);
    exp_t e;
    bit in_f, lead;
    int col, di, px, fx;
    logic [7:0] row;
    @(negedge clk);
    advance(cyc);
    hcount_in = 11'(h); vcount_in = 11'(v);
    hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb;
    rgb_in = rgb; rst = r;
    if (r) begin
      rst_pend = 1;
      rst_at = cyc + 1;
    end else if (vs && !prev_vs && !model_busy(cyc)) begin
      conv_valid = 1;
      conv_start = cyc + 1;
      for (int p = 0; p < NP; p++) pend_score[p] = int'(score_in[p*SW +: SW]);
    end
    prev_vs = vs;
    e.t = cyc; e.code = 7'h20; e.line = 4'd0;
    in_f = 0; col = 0;
    if (!hb && !vb && v >= YS && v < YS + 16 * SC) begin
      for (int p = 0; p < NP; p++) begin
        fx = XS + p * XP;
        if (h >= fx && h < fx + DIG * 8 * SC) begin
          in_f = 1;
          px = (h - fx) / SC;
          col = px % 8;
          di = px / 8;
          e.line = 4'(((v - YS) / SC) % 16);
          lead = 1;
          for (int k = 0; k <= di; k++) if (digit_of(disp_score[p], k) != 0) lead = 0;
          e.code = (lead && di != DIG - 1) ? 7'h20 : 7'(48 + digit_of(disp_score[p], di));
        end
      end
    end
    row = font_row(e.code, e.line);
    e.rgb = (in_f && row[7 - col]) ? FG : rgb;
    e.timing = {11'(h), 11'(v), hs, vs, hb, vb};
    exp_q.push_back(e);
  endtask

  // Monitor: busy/overflow every cycle, pixel records once they reach the outputs.
  logic [6:0] prev_code = 7'h20;
  logic [3:0] prev_line = '0;
  initial begin
    exp_t e;
    logic [NP-1:0] ovf_exp;
    forever begin
      @(negedge clk); #1;
      if (armed) begin
        checkOutput("busy", 32'(busy), 32'(model_busy(cyc)));
        for (int p = 0; p < NP; p++) ovf_exp[p] = (disp_score[p] > MAXV);
        checkOutput("overflow", 32'(overflow), 32'(ovf_exp));
        while (exp_q.size() > 0 && exp_q[0].t + 2 <= cyc) begin
          e = exp_q.pop_front();
          if (e.t + 2 != cyc) checkOutput("latency", 32'(cyc), 32'(e.t + 2));
          checkOutput("rgb_out", 32'(rgb_out), 32'(e.rgb));
          checkOutput("timing_out", 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
                      32'(e.timing));
          checkOutput("char_code", 32'(prev_code), 32'(e.code));
          checkOutput("char_line", 32'(prev_line), 32'(e.line));
        end
        prev_code = char_code;
        prev_line = char_line;
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 12'($urandom), 0);
  endtask

  task automatic frame_pulse();
    applyStimulus(0, 600, 0, 1, 1, 1, 12'($urandom), 0);
    applyStimulus(0, 601, 0, 1, 1, 1, 12'($urandom), 0);
    idle(CONV_CYC + 4);
  endtask

  task automatic scan(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++)
      applyStimulus(h, v, 1'($urandom), 0, 0, 0, 12'($urandom), 0);
  endtask

  task automatic set_scores(input int s0, input int s1);
    score_in = {7'(s1), 7'(s0)};
  endtask

  task automatic pulse_reset();
    applyStimulus(0, 0, 0, 0, 0, 0, 12'h000, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 12'h000, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 12'h000, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 12'h000, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 12'h000, 0);
  endtask

  initial begin
    foreach (disp_score[p]) begin disp_score[p] = 0; pend_score[p] = 0; end
    @(negedge clk);
    checkOutput("reset_rgb", 32'(rgb_out), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_overflow", 32'(overflow), 32'h0);
    checkOutput("reset_char_code", 32'(char_code), 32'h20);
    checkOutput("reset_timing", 32'({hcount_out, vcount_out, hsync_out, vsync_out}), 32'h0);
    armed = 1;
    idle(3);

    // All-zero display: only the last digit of each field shows '0'.
    scan(40, 444, 484);
    scan(33, 540, 580);

    set_scores(7, 42);
    frame_pulse();
    scan(36, 444, 484);
    scan(50, 540, 580);

    set_scores(127, 3);
    frame_pulse();
    scan(41, 446, 482);
    set_scores(5, 100);
    frame_pulse();
    scan(41, 446, 482);
    scan(60, 542, 578);

    // A second vsync edge while converting must be ignored.
    set_scores(88, 9);
    applyStimulus(0, 600, 0, 1, 1, 1, 12'($urandom), 0);
    applyStimulus(0, 601, 0, 0, 1, 1, 12'($urandom), 0);
    idle(3);
    set_scores(11, 120);
    applyStimulus(0, 602, 0, 1, 1, 1, 12'($urandom), 0);
    applyStimulus(0, 603, 0, 1, 1, 1, 12'($urandom), 0);
    idle(CONV_CYC + 4);
    scan(45, 446, 482);
    scan(45, 542, 578);

    // Scaling with a single-pixel-wide glyph column.
    idle(4);
    font_mode = 0;
    idle(4);
    for (int v = 31; v <= 35; v++) scan(v, 446, 452);
    scan(63, 462, 482);
    scan(64, 462, 482);
    idle(4);
    font_mode = 1;
    idle(4);

    // Reset in the middle of a conversion.
    set_scores(64, 77);
    applyStimulus(0, 600, 0, 1, 1, 1, 12'h000, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 12'h000, 0);
    idle(3);
    pulse_reset();
    scan(40, 446, 482);
    frame_pulse();
    scan(40, 446, 482);
    scan(40, 542, 578);

    for (int it = 0; it < 6; it++) begin
      set_scores(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
      frame_pulse();
      for (int i = 0; i < 80; i++)
        applyStimulus(int'($urandom_range(440, 660)), int'($urandom_range(28, 70)),
                      1'($urandom), 0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                      12'($urandom), 0);
    end

    idle(4);
    repeat (3) @(negedge clk);
    #2;
    checkOutput("drain", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
